fir_coeff_loader: RTL and testbench
===================================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
- REQ-001 Parameter COEFF_WIDTH, default 8: bit width of one signed two's-complement coefficient.
- REQ-002 Parameter NUM_TAPS, default 4: number of coefficients per set; legal range 2..64.
- REQ-003 clk  input  1: single clock; all logic is rising-edge.
- REQ-004 rst_n  input  1: reset, asynchronous, active-low.
- REQ-005 load_start  input  1: single-cycle request to begin loading a new coefficient set.
- REQ-006 coeff_in  input  COEFF_WIDTH: incoming coefficient word.
- REQ-007 coeff_valid  input  1: coeff_in is valid this cycle.
- REQ-008 coeff_ready  output  1: loader accepts a word this cycle; a word transfers when coeff_valid and coeff_ready are both 1.
- REQ-009 coeff  output  NUM_TAPS*COEFF_WIDTH: committed flat coefficient bus driving the FIR filter coeff port.
- REQ-010 busy  output  1: a load is in progress.
- REQ-011 done  output  1: one-cycle pulse when a new set is committed to coeff.
- REQ-012 error  output  1: sticky flag, set on checksum failure; cleared by the next load_start.

Function
- REQ-013 FSM states: IDLE, LOAD, CHECK, COMMIT; CHECK exists only when COEFF_CHECKSUM_EN is defined.
- REQ-014 IDLE: coeff_ready=0, busy=0; load_start -> LOAD, tap counter cleared to 0, error cleared.
- REQ-015 LOAD: coeff_ready=1, busy=1; each transfer writes coeff_in into a shadow register, slot index = tap counter, and the counter increments.
- REQ-016 Packing: the first received word occupies coeff[NUM_TAPS*COEFF_WIDTH-1 -: COEFF_WIDTH]; the last tap word occupies coeff[COEFF_WIDTH-1:0].
- REQ-017 After the transfer of word NUM_TAPS-1: go to COMMIT, or to CHECK when checksum is enabled.
- REQ-018 COMMIT lasts one cycle: coeff <= shadow, done=1, coeff_ready=0; next state IDLE.
- REQ-019 Commit is atomic: coeff never shows a partially loaded set; coeff holds its previous value throughout LOAD and CHECK.
- REQ-020 coeff_valid=0 in LOAD stalls indefinitely with no timeout; shadow and counter hold.
- REQ-021 load_start while busy (LOAD or CHECK) restarts the load: counter cleared to 0, shadow contents discarded, coeff unchanged, error cleared; a transfer in the same cycle is ignored.
- REQ-022 load_start in the COMMIT cycle: the commit completes, then the FSM enters LOAD on the next cycle.
- REQ-023 Words presented in IDLE or COMMIT are not accepted (coeff_ready=0).
- REQ-024 Latency: done asserts exactly one cycle after the last tap transfer (no checksum), or two cycles after the checksum transfer (checksum).

Reset
- REQ-025 rst_n=0 asynchronously forces state IDLE, counter 0, shadow 0, coeff 0, coeff_ready 0, busy 0, done 0, error 0.
- REQ-026 Reset during LOAD or CHECK abandons the load with no commit; after release the block waits in IDLE for load_start.

Configuration
- REQ-027 Macro COEFF_CHECKSUM_EN defined: after the NUM_TAPS tap words, LOAD accepts one extra checksum word, then enters CHECK for one cycle.
- REQ-028 CHECK passes when (sum of all taps + checksum word) mod 2^COEFF_WIDTH == 0; pass -> COMMIT; fail -> error=1, no commit, no done, next state IDLE.
- REQ-029 Macro COEFF_CHECKSUM_EN undefined: no checksum word and no CHECK state; error is tied to 0.

Verification
- REQ-030 Basic load, no checksum, NUM_TAPS=4, COEFF_WIDTH=8: load_start, then send 4, 3, -1, -2 back-to-back -> coeff=32'h0403FFFE one cycle after the 4th transfer, done pulses once, busy falls.
- REQ-031 Stall: same words with coeff_valid dropped for 5 cycles after word 2 -> identical coeff; coeff stays at the old value until commit.
- REQ-032 Restart: send 4, 3, then load_start, then 1, 2, 3, 4 -> coeff=32'h01020304, a single done pulse.
- REQ-033 Reset mid-load: assert rst_n=0 after 2 words -> all outputs 0; after release, a load of 5, 5, 5, 5 gives coeff=32'h05050505.
- REQ-034 Checksum pass (macro defined): taps 4, 3, -1, -2 plus checksum -4 (8'hFC) -> commit with coeff=32'h0403FFFE, error=0.
- REQ-035 Checksum fail (macro defined): same taps plus checksum 8'h00 -> error=1, no done, coeff keeps its prior value; the next load_start clears error.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Receives a set of NUM_TAPS signed coefficients over a valid/ready stream
//   into a shadow register and commits the complete set to the coeff bus in a
//   single cycle. The coeff bus therefore never shows a partially loaded set.
//
//   Optional feature macro: COEFF_CHECKSUM_EN
//     - When defined, one extra checksum word follows the taps.
//     - The set commits only if (sum of taps + checksum) mod 2^COEFF_WIDTH == 0.
//     - Otherwise the sticky error flag is set.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   load_start   one-cycle request to (re)start loading a set
//   coeff_in     incoming coefficient word
//   coeff_valid  coeff_in valid this cycle
//   coeff_ready  loader accepts a word this cycle (LOAD only)
//   coeff        committed flat coefficient bus; the first word is in the MSBs
//   busy         load in progress (LOAD / CHECK)
//   done         one-cycle pulse in the cycle the new set appears on coeff
//   error        sticky checksum failure; cleared by load_start
module fir_coeff_loader #(
    parameter int COEFF_WIDTH = 8,
    parameter int NUM_TAPS    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_start,
    input  logic [COEFF_WIDTH-1:0]          coeff_in,
    input  logic                            coeff_valid,
    output logic                            coeff_ready,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int CNT_W = $clog2(NUM_TAPS + 1);
`ifdef COEFF_CHECKSUM_EN
    localparam int LAST_IDX = NUM_TAPS;      // the checksum word follows the taps
`else
    localparam int LAST_IDX = NUM_TAPS - 1;
`endif

`ifdef COEFF_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT} state_t;
    logic [COEFF_WIDTH-1:0] sum_q;
    logic                   err_q;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
`endif

    state_t                          state_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [NUM_TAPS*COEFF_WIDTH-1:0] shadow_q, shadow_d, coeff_q;
    logic                            ready_q, busy_q, done_q;
    logic                            last_xfer;

    // The shadow image with the current word merged into slot cnt_q.
    // Tap i lives at bit (NUM_TAPS-1-i)*W, so the first word lands in the MSBs.
    // The checksum index (cnt_q == NUM_TAPS) matches no slot, so the checksum
    // word is not stored in the shadow.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_TAPS; i++)
            if (cnt_q == CNT_W'(i))
                shadow_d[(NUM_TAPS-1-i)*COEFF_WIDTH +: COEFF_WIDTH] = coeff_in;
    end

    assign last_xfer = (cnt_q == CNT_W'(LAST_IDX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            coeff_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
            sum_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // load_start has the same effect from every state.
            // - From LOAD or CHECK it discards the partial set.
            // - From COMMIT it follows a commit that has already landed.
            if (load_start) begin
                state_q  <= S_LOAD;
                cnt_q    <= '0;
                shadow_q <= '0;
                ready_q  <= 1'b1;
                busy_q   <= 1'b1;
`ifdef COEFF_CHECKSUM_EN
                sum_q    <= '0;
                err_q    <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_LOAD: if (coeff_valid) begin
                        shadow_q <= shadow_d;
                        cnt_q    <= cnt_q + 1'b1;
`ifdef COEFF_CHECKSUM_EN
                        sum_q    <= sum_q + coeff_in;
                        if (last_xfer) begin
                            state_q <= S_CHECK;
                            ready_q <= 1'b0;
                        end
`else
                        // The commit is registered on entry to COMMIT.
                        // coeff and done therefore appear together in the
                        // cycle after the last transfer.
                        if (last_xfer) begin
                            state_q <= S_COMMIT;
                            coeff_q <= shadow_d;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
`endif
                    end
`ifdef COEFF_CHECKSUM_EN
                    S_CHECK: begin
                        busy_q <= 1'b0;
                        if (sum_q == '0) begin
                            state_q <= S_COMMIT;
                            coeff_q <= shadow_q;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
`endif
                    S_COMMIT: state_q <= S_IDLE;
                    default:  state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign coeff_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign coeff       = coeff_q;
`ifdef COEFF_CHECKSUM_EN
    assign error       = err_q;
`else
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed testbench for fir_coeff_loader (NUM_TAPS=4, COEFF_WIDTH=8).
// Works with or without COEFF_CHECKSUM_EN.
// With the macro defined, each load is closed with the checksum word that
// makes the set pass, followed by the CHECK cycle.
module tb_fir_coeff_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  coeff_in = '0;
    logic        coeff_valid = 1'b0;
    logic        coeff_ready, busy, done, error;
    logic [31:0] coeff;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  sum_acc = '0;

    fir_coeff_loader #(.COEFF_WIDTH(8), .NUM_TAPS(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .coeff_in(coeff_in),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff(coeff),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start();
        load_start = 1'b1; sum_acc = '0;
        step();
        load_start = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] w);
        coeff_in = w; coeff_valid = 1'b1; sum_acc = sum_acc + w;
        step();
        coeff_valid = 1'b0;
    endtask

    // With the checksum feature, send the checksum word that makes the set
    // pass, then let the CHECK cycle go by.
    task automatic tail();
`ifdef COEFF_CHECKSUM_EN
        xfer(8'h00 - sum_acc);
        step();
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_cmp++; if (coeff !== 32'h0) begin n_bad++; $display("FAIL reset_coeff got %h want %h", coeff, 32'h0); end
        n_cmp++; if (coeff_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", coeff_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want 0", error); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (coeff_ready !== 1'b0) begin n_bad++; $display("FAIL reset_idle_ready got %b want 0", coeff_ready); end
    endtask

    task automatic test_basic();
        start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
        n_cmp++; if (coeff_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %b want 1", coeff_ready); end
        xfer(8'd4); xfer(8'd3); xfer(8'hFF);
        n_cmp++; if (coeff !== 32'h0) begin n_bad++; $display("FAIL basic_hold got %h want %h", coeff, 32'h0); end
        xfer(8'hFE);
        tail();
        n_cmp++; if (coeff !== 32'h0403FFFE) begin n_bad++; $display("FAIL basic_coeff got %h want %h", coeff, 32'h0403FFFE); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall got %b want 0", busy); end
        n_cmp++; if (coeff_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_commit got %b want 0", coeff_ready); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_restart();
        start();
        xfer(8'd4); xfer(8'd3);
        // This transfer coincides with load_start and must be discarded.
        load_start = 1'b1; coeff_in = 8'h77; coeff_valid = 1'b1; sum_acc = '0;
        step();
        load_start = 1'b0; coeff_valid = 1'b0;
        n_cmp++; if (coeff !== 32'h0403FFFE) begin n_bad++; $display("FAIL restart_hold got %h want %h", coeff, 32'h0403FFFE); end
        xfer(8'd1); xfer(8'd2); xfer(8'd3);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_early_done got %b want 0", done); end
        xfer(8'd4);
        tail();
        n_cmp++; if (coeff !== 32'h01020304) begin n_bad++; $display("FAIL restart_coeff got %h want %h", coeff, 32'h01020304); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_done got %b want 1", done); end
    endtask

    task automatic test_stall();
        start();
        xfer(8'd4); xfer(8'd3);
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (coeff_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready got %b want 1", coeff_ready); end
        n_cmp++; if (coeff !== 32'h01020304) begin n_bad++; $display("FAIL stall_hold got %h want %h", coeff, 32'h01020304); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stall_done got %b want 0", done); end
        xfer(8'hFF); xfer(8'hFE);
        tail();
        n_cmp++; if (coeff !== 32'h0403FFFE) begin n_bad++; $display("FAIL stall_coeff got %h want %h", coeff, 32'h0403FFFE); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done_end got %b want 1", done); end
    endtask

    task automatic test_reset_midload();
        start();
        xfer(8'd9); xfer(8'd9);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (coeff !== 32'h0) begin n_bad++; $display("FAIL midrst_coeff got %h want %h", coeff, 32'h0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (coeff_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %b want 0", coeff_ready); end
        step();
        rst_n = 1'b1;
        coeff_in = 8'h33; coeff_valid = 1'b1;
        step(); step();
        coeff_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got busy=%b done=%b want 0 0", busy, done); end
        start();
        xfer(8'd5); xfer(8'd5); xfer(8'd5); xfer(8'd5);
        tail();
        n_cmp++; if (coeff !== 32'h05050505) begin n_bad++; $display("FAIL midrst_coeff_after got %h want %h", coeff, 32'h05050505); end
    endtask

    task automatic test_back_to_back();
        start();
        xfer(8'h10); xfer(8'h20); xfer(8'h30); xfer(8'h40);
        tail();
        // Now in COMMIT: a load_start here must enter LOAD straight after.
        load_start = 1'b1; sum_acc = '0;
        step();
        load_start = 1'b0;
        n_cmp++; if (coeff !== 32'h10203040) begin n_bad++; $display("FAIL b2b_first got %h want %h", coeff, 32'h10203040); end
        n_cmp++; if (busy !== 1'b1 || coeff_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_reload got busy=%b ready=%b want 1 1", busy, coeff_ready); end
        xfer(8'h11); xfer(8'h22); xfer(8'h33); xfer(8'h44);
        tail();
        n_cmp++; if (coeff !== 32'h11223344) begin n_bad++; $display("FAIL b2b_second got %h want %h", coeff, 32'h11223344); end
    endtask

    task automatic test_idle_ignore();
        step();
        coeff_in = 8'hAA; coeff_valid = 1'b1;
        step(); step(); step();
        n_cmp++; if (coeff_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready got %b want 0", coeff_ready); end
        coeff_valid = 1'b0;
        start();
        xfer(8'd1); xfer(8'd2); xfer(8'd3); xfer(8'd4);
        tail();
        n_cmp++; if (coeff !== 32'h01020304) begin n_bad++; $display("FAIL idle_then_load got %h want %h", coeff, 32'h01020304); end
    endtask

`ifdef COEFF_CHECKSUM_EN
    task automatic test_checksum();
        start();
        xfer(8'd4); xfer(8'd3); xfer(8'hFF); xfer(8'hFE); xfer(8'hFC);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL cs_check_cycle got %b want 0", done); end
        step();
        n_cmp++; if (done !== 1'b1 || coeff !== 32'h0403FFFE || error !== 1'b0) begin n_bad++; $display("FAIL cs_pass got done=%b coeff=%h err=%b want 1 0403fffe 0", done, coeff, error); end
        start();
        xfer(8'h10); xfer(8'h10); xfer(8'h10); xfer(8'h10); xfer(8'h00);
        step();
        n_cmp++; if (error !== 1'b1 || done !== 1'b0 || coeff !== 32'h0403FFFE) begin n_bad++; $display("FAIL cs_fail got err=%b done=%b coeff=%h want 1 0 0403fffe", error, done, coeff); end
        step();
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL cs_sticky got %b want 1", error); end
        start();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL cs_clear got %b want 0", error); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_stall();
        test_reset_midload();
        test_back_to_back();
        test_idle_ignore();
`ifdef COEFF_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
